// File: rtl/bof_crash_ctrl.sv
// Arms on a heap-overflow load, then raises a held crash request if a JAL/JALR
// follows within a bounded window of distinct instructions.
module bof_crash_ctrl #(
    parameter int WINDOW  = 8,
    parameter int COUNT_W = 8,
    parameter int STICKY  = 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               en_crash_i,
    input  logic               to_crash_i,
    input  logic               instr_valid_i,
    input  logic [31:0]        instr_pc_i,
    input  logic               instr_is_jump_i,
    input  logic               crash_ack_i,
    input  logic               clear_i,
    output logic               crash_req_o,
    output logic               armed_o,
    output logic               halted_o,
    output logic [31:0]        crash_pc_o,
    output logic [31:0]        trigger_pc_o,
    output logic [COUNT_W-1:0] crash_count_o
);

    // state | meaning
    // IDLE  | waiting for an overflow-range load
    // ARMED | window open, watching for a control transfer
    // FIRE  | crash request raised, waiting for acknowledge
    // HALT  | parked after a crash until software clears
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_FIRE  = 2'd2,
        S_HALT  = 2'd3
    } state_e;

    localparam logic [7:0] WIN = 8'(WINDOW);

    state_e             state_q, state_d;
    logic [7:0]         win_q, win_d;
    logic [31:0]        last_pc_q;
    logic [31:0]        crash_pc_q, crash_pc_d;
    logic [31:0]        trig_pc_q, trig_pc_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               req_q, armed_q, halted_q;
    logic               new_instr;

    assign new_instr = instr_valid_i && (instr_pc_i != last_pc_q);

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        crash_pc_d = crash_pc_q;
        trig_pc_d  = trig_pc_q;
        count_d    = count_q;

        if (clear_i) begin
            state_d = S_IDLE;
            win_d   = '0;
        end else if (!en_crash_i && (state_q == S_IDLE || state_q == S_ARMED)) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (en_crash_i && to_crash_i) begin
                        state_d   = S_ARMED;
                        win_d     = WIN;
                        trig_pc_d = instr_pc_i;
                    end
                end
                S_ARMED: begin
                    // jump beats both reload and timeout on the same instruction
                    if (new_instr) begin
                        if (instr_is_jump_i) begin
                            state_d    = S_FIRE;
                            crash_pc_d = instr_pc_i;
                        end else if (to_crash_i) begin
                            win_d = WIN;
                        end else if (win_q == 8'd0) begin
                            state_d = S_IDLE;
                        end else begin
                            win_d = win_q - 8'd1;
                        end
                    end
                end
                S_FIRE: begin
                    if (crash_ack_i) begin
                        if (count_q != '1) count_d = count_q + COUNT_W'(1);
                        state_d = (STICKY != 0) ? S_HALT : S_IDLE;
                    end
                end
                S_HALT: begin
                    state_d = S_HALT;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            win_q      <= '0;
            last_pc_q  <= '0;
            crash_pc_q <= '0;
            trig_pc_q  <= '0;
            count_q    <= '0;
            req_q      <= 1'b0;
            armed_q    <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            crash_pc_q <= crash_pc_d;
            trig_pc_q  <= trig_pc_d;
            count_q    <= count_d;
            req_q      <= (state_d == S_FIRE);
            armed_q    <= (state_d == S_ARMED);
            halted_q   <= (state_d == S_HALT);
            if (new_instr) last_pc_q <= instr_pc_i;
        end
    end

    assign crash_req_o   = req_q;
    assign armed_o       = armed_q;
    assign halted_o      = halted_q;
    assign crash_pc_o    = crash_pc_q;
    assign trigger_pc_o  = trig_pc_q;
    assign crash_count_o = count_q;

endmodule

// File: doc/bof_crash_ctrl.md
# bof_crash_ctrl

Downstream consumer of the heap-overflow detector's `to_crash` flag. It arms when a load has hit a recorded overflow range, then watches the decoded instruction stream for a following control transfer (JAL/JALR) within a bounded window. When one arrives, it raises a held exception request toward the commit/exception logic, holding it until that logic acknowledges. It also latches diagnostic state (offending PC, trigger PC, event count) and can park in a sticky halt state until software clears it.

## Interface
Parameters:
- `WINDOW`, default 8: instructions (distinct PCs) allowed between arming and the jump; range 1..255.
- `COUNT_W`, default 8: width of the saturating crash-event counter.
- `STICKY`, default 1: 1 means go to HALT after acknowledge; 0 means return to IDLE.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `en_crash_i` in 1: detection enable.
- `to_crash_i` in 1: overflow-range load flag from the detector (level).
- `instr_valid_i` in 1: decoded instruction present this cycle.
- `instr_pc_i` in 32: PC of the decoded instruction.
- `instr_is_jump_i` in 1: decoded op is JAL or JALR.
- `crash_ack_i` in 1: exception logic has taken the request.
- `clear_i` in 1: synchronous clear, one-cycle pulse.
- `crash_req_o` out 1: exception request.
- `armed_o` out 1: state is ARMED.
- `halted_o` out 1: state is HALT.
- `crash_pc_o` out 32: PC of the jump that fired.
- `trigger_pc_o` out 32: PC at the time of arming.
- `crash_count_o` out COUNT_W: number of acknowledged crashes.

## Operation
- FSM states: IDLE, ARMED, FIRE, HALT. All outputs are registered.
- Transition priority, highest first: `clear_i`, then `!en_crash_i`, then state logic.
- `clear_i` in any state:
  - next state IDLE; window counter reset.
  - `crash_count_o`, `crash_pc_o` and `trigger_pc_o` are retained.
- `!en_crash_i` in IDLE or ARMED: next state IDLE.
  - In FIRE or HALT it has no effect; a request already raised is completed.
- New-instruction rule: an instruction counts only if `instr_valid_i` is high and `instr_pc_i` differs from the last counted PC.
  - The last counted PC register resets to 0 and updates on every counted instruction, in every state.
- IDLE:
  - If `en_crash_i && to_crash_i`, go to ARMED.
  - Load the window counter with `WINDOW`.
  - Latch `trigger_pc_o <= instr_pc_i`.
- ARMED:
  - Counted instruction with `instr_is_jump_i`: go to FIRE and latch `crash_pc_o <= instr_pc_i`. The jump check takes priority over the decrement and over timeout.
  - Counted non-jump instruction: decrement the counter.
  - If `to_crash_i` is high on that cycle, reload the counter to `WINDOW` instead of decrementing.
  - If the counter is 0 when a counted non-jump instruction arrives and `to_crash_i` is low, go to IDLE (timeout).
  - Non-counted cycles (invalid or repeated PC) leave the counter unchanged.
- FIRE:
  - `crash_req_o = 1`; `crash_pc_o` is held stable.
  - On `crash_ack_i`, `crash_count_o` increments, saturating at all-ones.
  - Next state is HALT if `STICKY`, otherwise IDLE.
  - `to_crash_i` and jumps are ignored in this state.
- HALT: `halted_o = 1`, `crash_req_o = 0`. Leaves only on `clear_i`.
- Counter width is 8 bits; `WINDOW` is truncated to 8 bits.

## Timing
- Reset values:
  - state IDLE.
  - `crash_req_o`, `armed_o`, `halted_o` = 0.
  - `crash_pc_o`, `trigger_pc_o` = 0.
  - `crash_count_o` = 0.
- Arming latency: `to_crash_i` sampled at edge N gives `armed_o = 1` after edge N.
- Fire latency: jump sampled at edge M gives `crash_req_o = 1` after edge M, with `crash_pc_o` valid in the same cycle.
- Handshake:
  - `crash_req_o` stays high until the edge where `crash_ack_i` is sampled high, and is 0 after that edge.
  - `crash_ack_i` while not in FIRE is ignored.
- A jump on the same cycle as arming (IDLE with `to_crash_i` and a jump) does not fire; it only arms.
- `clear_i` together with `crash_ack_i` in FIRE: clear wins. State goes to IDLE and the counter does not increment.
- Asynchronous reset mid-FIRE drops `crash_req_o` immediately, without waiting for a clock edge.
- Window exhaustion: with `WINDOW = W`, exactly W counted non-jump instructions are tolerated. The (W+1)-th counted non-jump instruction times out.

## Test plan
- Basic fire, `WINDOW = 8`:
  - Stimulus: `to_crash_i` at PC 0x100; non-jumps at 0x104 and 0x108; JAL at 0x10C; `crash_ack_i` 3 cycles later.
  - Required: `crash_req_o` high for 3 cycles; `crash_pc_o = 0x10C`, `trigger_pc_o = 0x100`; `crash_count_o = 1`; `halted_o = 1`.
- Timeout, `WINDOW = 2`:
  - Stimulus: arm, then 3 distinct non-jump PCs, then a jump.
  - Required: `armed_o` drops after the 3rd non-jump; `crash_req_o` never asserts.
- Repeated PC and reload, `WINDOW = 2`:
  - Stimulus: arm; the same PC held valid for 10 cycles; `to_crash_i` re-pulsed; then 2 non-jumps and a JALR.
  - Required: no timeout; fires with `crash_pc_o` equal to the JALR PC.
- Enable drop:
  - Stimulus: arm, then deassert `en_crash_i`.
  - Required: IDLE next cycle; a later jump does not fire.
  - Stimulus: deassert `en_crash_i` while in FIRE.
  - Required: request held until ack.
- Clear and non-sticky, `STICKY = 0`:
  - Stimulus: fire and ack.
  - Required: back to IDLE, count = 1.
  - Stimulus: `clear_i` together with `crash_ack_i` in FIRE.
  - Required: IDLE; count unchanged.
- Saturation and reset, `COUNT_W = 2`:
  - Stimulus: 5 acknowledged crashes.
  - Required: `crash_count_o = 3`.
  - Stimulus: `rst_ni` low mid-FIRE.
  - Required: all outputs 0 asynchronously.
